// File: rtl/hough_accum_arbiter.sv
// Hough accumulator RAM owner: arbitrates votes against host reads, performs
// forwarded read-modify-write increments, and sweeps the RAM to zero on demand.
module hough_accum_arbiter #(
  parameter int DEPTH  = 1601,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              vote_valid,
  input  logic [ADDR_W-1:0] vote_addr,
  output logic              vote_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_data_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [CNT_W-1:0]  mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [CNT_W-1:0]  mem_wdata,
  output logic              overflow,
  output logic              addr_err
);

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;
  typedef enum logic {G_VOTE, G_RD} grant_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  grant_t            last_grant;
  logic [ADDR_W-1:0] clr_ptr;

  // S1: request waiting for RAM data; W: increment being written; P: last write.
  logic              s1_valid, s1_vote, s1_oor;
  logic [ADDR_W-1:0] s1_addr;
  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [CNT_W-1:0]  w_data;
  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [CNT_W-1:0]  p_data;
  logic [CNT_W-1:0]  rd_hold;

  logic              run, vote_acc, rd_acc, any_acc, acc_oor, sat;
  logic [ADDR_W-1:0] acc_addr;
  logic [CNT_W-1:0]  base, inc;

  assign run        = (state == RUN);
  assign clear_busy = !run;
  assign vote_ready = run && !(rd_valid && last_grant == G_VOTE);
  assign rd_ready   = run && !(vote_valid && last_grant == G_RD);
  assign vote_acc   = vote_valid && vote_ready;
  assign rd_acc     = rd_valid && rd_ready;
  assign any_acc    = vote_acc || rd_acc;
  assign acc_addr   = rd_acc ? rd_addr : vote_addr;
  assign acc_oor    = ({1'b0, acc_addr} >= DEPTH_L);
  assign mem_raddr  = any_acc ? acc_addr : '0;

  // The RAM misses the write committed on the same edge as the read, so P covers it.
  assign base = (w_valid && w_addr == s1_addr) ? w_data :
                (p_valid && p_addr == s1_addr) ? p_data : mem_rdata;
  assign sat  = (base == {CNT_W{1'b1}});
  assign inc  = sat ? base : base + 1'b1;

  assign rd_data_valid = s1_valid && !s1_vote;
  assign rd_data       = rd_data_valid ? (s1_oor ? '0 : base) : rd_hold;

  // Clear writes are held off while reset is asserted.
  assign mem_we    = (state == CLEAR) ? !reset : w_valid;
  assign mem_waddr = (state == CLEAR) ? clr_ptr : w_addr;
  assign mem_wdata = (state == CLEAR) ? '0 : w_data;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_ptr == LAST_BIN) state_next = RUN;
      RUN:     if (clear_start) state_next = DRAIN;
      DRAIN:   if (!s1_valid && !w_valid) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      last_grant <= G_VOTE;
      s1_valid   <= 1'b0;
      s1_vote    <= 1'b0;
      s1_oor     <= 1'b0;
      s1_addr    <= '0;
      w_valid    <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      p_valid    <= 1'b0;
      p_addr     <= '0;
      p_data     <= '0;
      rd_hold    <= '0;
      overflow   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state <= state_next;

      if (state == CLEAR && clr_ptr != LAST_BIN) clr_ptr <= clr_ptr + 1'b1;
      else                                       clr_ptr <= '0;

      if (vote_valid && rd_valid && any_acc) last_grant <= rd_acc ? G_RD : G_VOTE;

      s1_valid <= any_acc;
      s1_vote  <= vote_acc;
      s1_oor   <= acc_oor;
      s1_addr  <= acc_addr;

      w_valid <= s1_valid && s1_vote && !s1_oor;
      w_addr  <= s1_addr;
      w_data  <= inc;

      p_valid <= mem_we;
      p_addr  <= mem_waddr;
      p_data  <= mem_wdata;

      if (rd_data_valid) rd_hold <= rd_data;

      if (state == CLEAR)                               overflow <= 1'b0;
      else if (s1_valid && s1_vote && !s1_oor && sat)   overflow <= 1'b1;

      if (state == CLEAR)           addr_err <= 1'b0;
      else if (any_acc && acc_oor)  addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hough_accum_arbiter.sv
// Scoreboard bench for hough_accum_arbiter with a narrow counter so saturation is reachable.
module tb_hough_accum_arbiter;
  localparam int DEPTH  = 1601;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear_start = 1'b0;
  logic              clear_busy;
  logic              vote_valid = 1'b0;
  logic [ADDR_W-1:0] vote_addr = '0;
  logic              vote_ready;
  logic              rd_valid = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic              rd_data_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [ADDR_W-1:0] mem_raddr;
  logic [CNT_W-1:0]  mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CNT_W-1:0]  mem_wdata;
  logic              overflow;
  logic              addr_err;

  hough_accum_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
    .vote_valid(vote_valid), .vote_addr(vote_addr), .vote_ready(vote_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .overflow(overflow), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: one-cycle read latency, old data on read-during-write.
  logic [CNT_W-1:0] ram [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = CNT_W'($urandom);
  always @(posedge clock) begin
    mem_rdata <= ram[mem_raddr];
    if (mem_we) ram[mem_waddr] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain per-bin counts plus the expected sticky flags.
  int   model [DEPTH];
  bit   exp_ovf, exp_aerr;
  int   sb [$];

  task automatic model_clear();
    foreach (model[i]) model[i] = 0;
    exp_ovf  = 0;
    exp_aerr = 0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      model_clear();
      sb.delete();
    end else begin
      if (vote_valid && vote_ready) begin
        if (vote_addr >= DEPTH)            exp_aerr = 1;
        else if (model[vote_addr] == MAXC) exp_ovf  = 1;
        else                               model[vote_addr]++;
      end
      if (rd_valid && rd_ready) begin
        if (rd_addr >= DEPTH) begin
          exp_aerr = 1;
          sb.push_back(0);
        end else begin
          sb.push_back(model[rd_addr]);
        end
      end
      if (clear_start && !clear_busy) model_clear();
    end
  end

  // Monitor: compares every read result against the oldest expected value.
  always @(negedge clock) begin
    if (!reset && rd_data_valid) begin
      if (sb.size() == 0) check("rd_unexpected", 1, 0);
      else                check("rd_data", rd_data, sb.pop_front());
    end
  end

  // Write observer for directed checks.
  logic [ADDR_W-1:0] last_waddr;
  logic [CNT_W-1:0]  last_wdata;
  bit                capture = 0;
  int                we_count = 0;
  int                wq_addr [$];
  int                wq_data [$];
  always @(negedge clock) begin
    if (mem_we) begin
      last_waddr = mem_waddr;
      last_wdata = mem_wdata;
      we_count++;
      if (capture) begin
        wq_addr.push_back(mem_waddr);
        wq_data.push_back(mem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    vote_valid  = 1'b0;
    rd_valid    = 1'b0;
    clear_start = 1'b0;
  endtask

  // Presents one request and holds it until accepted; returns at posedge+1.
  task automatic req(input bit is_vote, input int a);
    bit ok = 0;
    vote_valid = is_vote;
    rd_valid   = !is_vote;
    vote_addr  = ADDR_W'(a);
    rd_addr    = ADDR_W'(a);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (is_vote ? vote_ready : rd_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) check("req_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_run();
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (!clear_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("run_timeout", 0, 1);
    tick();
  endtask

  // Called at posedge+1 of the first clear-write cycle.
  task automatic check_sweep();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if (!(mem_we && mem_waddr == ADDR_W'(i) && mem_wdata == '0 && clear_busy &&
            !vote_ready && !rd_ready)) bad++;
      tick();
    end
    check("sweep_bad_cycles", bad, 0);
    @(negedge clock);
    check("run_clear_busy", clear_busy, 0);
    check("run_vote_ready", vote_ready, 1);
    check("run_overflow", overflow, 0);
    check("run_addr_err", addr_err, 0);
    tick();
  endtask

  function automatic int rand_addr();
    int r = $urandom_range(0, 19);
    if (r < 15) return $urandom_range(0, 15);
    if (r < 18) return $urandom_range(DEPTH - 2, DEPTH - 1);
    return $urandom_range(DEPTH, (1 << ADDR_W) - 1);
  endfunction

  initial begin
    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_clear_busy", clear_busy, 1);
    check("rst_outputs", {vote_ready, rd_ready, rd_data_valid, mem_we, overflow, addr_err}, 0);
    check("rst_data", {rd_data, mem_raddr, mem_waddr, mem_wdata}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    check_sweep();

    req(0, 800);
    idle();
    tick();

    // Back-to-back votes then an immediate read: needs W forwarding.
    for (int i = 0; i < 5; i++) req(1, 800);
    req(0, 800);
    idle();
    repeat (3) tick();
    check("b2b_last_waddr", last_waddr, 800);
    check("b2b_last_wdata", last_wdata, 5);

    // A,B,A,A exercises W and P forwarding.
    req(1, 10); req(1, 11); req(1, 10); req(1, 10);
    req(0, 10); req(0, 11);
    idle();
    tick();

    // Contention: first grant goes to the read, then alternates.
    vote_valid = 1'b1; vote_addr = 30;
    rd_valid   = 1'b1; rd_addr   = 30;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("arb_grant", {rd_valid && rd_ready, vote_valid && vote_ready},
            (k % 2 == 0) ? 2 : 1);
      tick();
    end
    idle();
    repeat (3) tick();

    // Saturation on a narrow counter.
    for (int i = 0; i < 17; i++) req(1, 5);
    idle();
    repeat (3) tick();
    @(negedge clock);
    check("sat_overflow", overflow, 1);
    check("sat_wdata", last_wdata, MAXC);
    tick();
    req(0, 5);
    idle();
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    wait_run();
    @(negedge clock);
    check("clr_overflow", overflow, 0);
    tick();
    req(0, 5);
    idle();
    tick();

    // In-flight votes must drain before the first clear write.
    req(1, 20); req(1, 21); req(1, 22);
    idle();
    clear_start = 1'b1;
    capture = 1;
    tick();
    clear_start = 1'b0;
    repeat (3) tick();
    capture = 0;
    check("drain_nwrites", wq_addr.size() >= 3, 1);
    if (wq_addr.size() >= 3) begin
      check("drain_w0_addr", wq_addr[0], 21);
      check("drain_w0_data", wq_data[0], 1);
      check("drain_w1_addr", wq_addr[1], 22);
      check("drain_w1_data", wq_data[1], 1);
      check("drain_clr0", {wq_addr[2], wq_data[2]}, 0);
    end
    wait_run();

    // Out-of-range vote: flag only, no write.
    req(1, DEPTH);
    idle();
    we_count = 0;
    repeat (4) tick();
    check("oor_no_write", we_count, 0);
    @(negedge clock);
    check("oor_addr_err", addr_err, 1);
    tick();

    // Randomized mix.
    for (int i = 0; i < 600; i++) begin
      vote_valid = ($urandom_range(0, 3) != 0);
      vote_addr  = ADDR_W'(rand_addr());
      rd_valid   = ($urandom_range(0, 2) == 0);
      rd_addr    = ADDR_W'(rand_addr());
      tick();
    end
    idle();
    repeat (4) tick();
    @(negedge clock);
    check("rand_overflow", overflow, exp_ovf);
    check("rand_addr_err", addr_err, exp_aerr);
    tick();
    for (int a = 0; a < 16; a++) req(0, a);
    req(0, DEPTH - 2);
    req(0, DEPTH - 1);
    idle();
    repeat (3) tick();

    // Reset with votes in flight restarts the sweep from bin 0.
    req(1, 40); req(1, 40); req(1, 40);
    idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check_sweep();
    req(0, 40);
    idle();
    repeat (3) tick();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
